// File: rtl/scan_sequencer_pkg.sv
// Shared types and constants for the scan sequencer slice.
// Optional feature macro SCAN_BLANK_EN (used by the interface and top; nothing here depends on it).
package scan_pkg;

  localparam int SEL_W     = 3;
  localparam int NUM_LINES = 8;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef logic [SEL_W-1:0] sel_t;

  // Preload values above the swept range are pulled down to the last index.
  function automatic sel_t clamp_sel(input sel_t v, input sel_t last);
    return (v > last) ? last : v;
  endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a controller (master) and the scan sequencer (slave).
// Optional feature macro SCAN_BLANK_EN adds the blank status line.
interface scan_sequencer_if;
  import scan_pkg::*;

  logic en;
  logic dir;
  logic load;
  sel_t load_val;
  logic in0;
  logic in1;
  logic in2;
  sel_t sel;
  logic tick;
  logic wrap;
`ifdef SCAN_BLANK_EN
  logic blank;

  modport master (output en, dir, load, load_val,
                  input  in0, in1, in2, sel, tick, wrap, blank);
  modport slave  (input  en, dir, load, load_val,
                  output in0, in1, in2, sel, tick, wrap, blank);
`else
  modport master (output en, dir, load, load_val,
                  input  in0, in1, in2, sel, tick, wrap);
  modport slave  (input  en, dir, load, load_val,
                  output in0, in1, in2, sel, tick, wrap);
`endif
endinterface

// File: rtl/scan_sequencer_tick_gen.sv
// Step prescaler: counts 0..DIV-1 while enabled, flags the terminal count combinationally.
// Optional feature macro SCAN_BLANK_EN has no effect on this block.
module tick_gen #(
  parameter int DIV   = 50000,
  parameter int DIV_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tc
);

  localparam logic [DIV_W-1:0] TERM = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign tc = en && (cnt == TERM);

  // Prescale counter: reset/clear to zero, hold while paused, roll over at the terminal count.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 3-bit decoder select through 0..LAST at the prescaled rate,
// with pause, direction, clamped preload, step tick and wrap pulse.
// Optional feature macro SCAN_BLANK_EN adds parameter BLANK and a blank output that is
// held high for BLANK cycles after each step, load or reset.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int DIV_W = 16,
  parameter int LAST  = 7
`ifdef SCAN_BLANK_EN
  , parameter int BLANK = 2
`endif
) (
  input logic            clk,
  input logic            rst,
  scan_sequencer_if.slave bus
);

  localparam sel_t LAST_S = sel_t'(LAST);

  sel_t sel_q;
  sel_t next_sel;
  logic next_wrap;
  logic tick_q;
  logic wrap_q;
  logic tc;
  logic step;

  tick_gen #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.en),
    .clear (bus.load),
    .tc    (tc)
  );

  // A preload in the same cycle pre-empts the step.
  assign step = tc && !bus.load;

  // Next select value and wrap flag for a step in the sampled direction.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    next_sel  = sel_q + 1'b1;
    next_wrap = 1'b0;
    if (bus.dir == DIR_DOWN) begin
      if (sel_q == '0) begin
        next_sel  = LAST_S;
        next_wrap = 1'b1;
      end else if (sel_q > LAST_S) begin
        next_sel = LAST_S;
      end else begin
        next_sel = sel_q - 1'b1;
      end
    end else if (sel_q >= LAST_S) begin
      next_sel  = '0;
      next_wrap = 1'b1;
    end
  end

  // Select register and 1-cycle pulses: reset, then load, then step.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (bus.load) begin
      sel_q  <= clamp_sel(bus.load_val, LAST_S);
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (step) begin
      sel_q  <= next_sel;
      tick_q <= 1'b1;
      wrap_q <= next_wrap;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end
  end

  assign bus.sel  = sel_q;
  assign bus.in0  = sel_q[0];
  assign bus.in1  = sel_q[1];
  assign bus.in2  = sel_q[2];
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;

`ifdef SCAN_BLANK_EN
  localparam logic [DIV_W-1:0] BLANK_HOLD = (BLANK > 0) ? DIV_W'(BLANK - 1) : '0;

  logic             blank_q;
  logic [DIV_W-1:0] blank_left;

  // Blanking window: restart on step/load/reset, stay high BLANK cycles, free-running of en.
  always_ff @(posedge clk) begin
    if (rst || bus.load || step) begin
      blank_q    <= (BLANK > 0);
      blank_left <= BLANK_HOLD;
    end else if (blank_left != '0) begin
      blank_left <= blank_left - 1'b1;
    end else begin
      blank_q <= 1'b0;
    end
  end

  assign bus.blank = blank_q;
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: a directed vector table, hand-written corner
// sequences and randomized stimulus, with two instances (DIV=4/LAST=7 and DIV=1/LAST=5)
// both tracked every cycle by a behavioural model. Honours SCAN_BLANK_EN when defined.
module tb_scan_sequencer;
  import scan_pkg::*;

  localparam int DIV_A  = 4;
  localparam int LAST_A = 7;
  localparam int DIV_B  = 1;
  localparam int LAST_B = 5;
`ifdef SCAN_BLANK_EN
  localparam int BLANK_A = 2;
  localparam int BLANK_B = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  scan_sequencer_if ifa ();
  scan_sequencer_if ifb ();

  scan_sequencer #(
    .DIV   (DIV_A),
    .DIV_W (4),
    .LAST  (LAST_A)
`ifdef SCAN_BLANK_EN
    , .BLANK (BLANK_A)
`endif
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  scan_sequencer #(
    .DIV   (DIV_B),
    .DIV_W (4),
    .LAST  (LAST_B)
`ifdef SCAN_BLANK_EN
    , .BLANK (BLANK_B)
`endif
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: position in the sweep, enabled cycles since the last step,
  // cycles since the last step/load/reset, and the pulses of the latest edge.
  typedef struct {
    int pos;
    int phase;
    int since;
    bit tick;
    bit wrap;
  } mdl_t;

  mdl_t ma = '{0, 0, 0, 1'b0, 1'b0};
  mdl_t mb = '{0, 0, 0, 1'b0, 1'b0};

  typedef struct {
    bit r;
    bit e;
    bit d;
    bit l;
    int lv;
    int sel;
    int tick;
    int wrap;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic mdl_t mdl_step(input mdl_t m, input int div, input int last,
                                    input bit r, input bit e, input bit d, input bit l,
                                    input int lv);
    mdl_t n;
    n      = m;
    n.tick = 1'b0;
    n.wrap = 1'b0;
    if (r) begin
      n.pos   = 0;
      n.phase = 0;
      n.since = 0;
    end else if (l) begin
      n.pos   = (lv > last) ? last : lv;
      n.phase = 0;
      n.since = 0;
    end else begin
      n.since = (m.since < 1000) ? m.since + 1 : m.since;
      if (e) begin
        n.phase = m.phase + 1;
        if (n.phase == div) begin
          n.phase = 0;
          n.since = 0;
          n.tick  = 1'b1;
          if (!d) begin
            n.wrap = (m.pos == last);
            n.pos  = (m.pos + 1) % (last + 1);
          end else begin
            n.wrap = (m.pos == 0);
            n.pos  = (m.pos + last) % (last + 1);
          end
        end
      end
    end
    return n;
  endfunction

  // One clock: drive inputs, advance both models at the edge, compare 1 ns later.
  task automatic cyc(input bit r, input bit e, input bit d, input bit l, input int lv);
    rst          = r;
    ifa.en       = e;
    ifa.dir      = d;
    ifa.load     = l;
    ifa.load_val = 3'(lv);
    ifb.en       = e;
    ifb.dir      = d;
    ifb.load     = l;
    ifb.load_val = 3'(lv);
    @(posedge clk);
    ma = mdl_step(ma, DIV_A, LAST_A, r, e, d, l, lv);
    mb = mdl_step(mb, DIV_B, LAST_B, r, e, d, l, lv);
    #1;
    check("a.sel",  32'(ifa.sel), ma.pos);
    check("a.bits", 32'({ifa.in2, ifa.in1, ifa.in0}), ma.pos);
    check("a.tick", 32'(ifa.tick), 32'(ma.tick));
    check("a.wrap", 32'(ifa.wrap), 32'(ma.wrap));
    check("b.sel",  32'(ifb.sel), mb.pos);
    check("b.bits", 32'({ifb.in2, ifb.in1, ifb.in0}), mb.pos);
    check("b.tick", 32'(ifb.tick), 32'(mb.tick));
    check("b.wrap", 32'(ifb.wrap), 32'(mb.wrap));
`ifdef SCAN_BLANK_EN
    check("a.blank", 32'(ifa.blank), 32'(ma.since < BLANK_A));
    check("b.blank", 32'(ifb.blank), 32'(mb.since < BLANK_B));
`endif
  endtask

  task automatic check_a(input string name, input int sel, input int tick, input int wrap);
    check({name, ".sel"},  32'(ifa.sel), sel);
    check({name, ".tick"}, 32'(ifa.tick), tick);
    check({name, ".wrap"}, 32'(ifa.wrap), wrap);
  endtask

  initial begin
    ifa.en = 1'b0; ifa.dir = 1'b0; ifa.load = 1'b0; ifa.load_val = '0;
    ifb.en = 1'b0; ifb.dir = 1'b0; ifb.load = 1'b0; ifb.load_val = '0;

    //          r  e  d  l  lv   sel tick wrap  (instance A: DIV=4, LAST=7)
    tbl[0]  = '{1, 0, 0, 0, 0,   0,  0,   0};
    tbl[1]  = '{1, 0, 0, 0, 0,   0,  0,   0};
    tbl[2]  = '{0, 1, 0, 0, 0,   0,  0,   0};
    tbl[3]  = '{0, 1, 0, 0, 0,   0,  0,   0};
    tbl[4]  = '{0, 1, 0, 0, 0,   0,  0,   0};
    tbl[5]  = '{0, 1, 0, 0, 0,   1,  1,   0};
    tbl[6]  = '{0, 1, 0, 1, 5,   5,  0,   0};
    tbl[7]  = '{0, 1, 0, 0, 0,   5,  0,   0};
    tbl[8]  = '{0, 0, 0, 0, 0,   5,  0,   0};
    tbl[9]  = '{0, 1, 0, 0, 0,   5,  0,   0};
    tbl[10] = '{0, 1, 0, 0, 0,   5,  0,   0};
    tbl[11] = '{0, 1, 0, 0, 0,   6,  1,   0};
    tbl[12] = '{0, 1, 1, 0, 0,   6,  0,   0};
    tbl[13] = '{0, 1, 1, 1, 0,   0,  0,   0};
    tbl[14] = '{0, 1, 1, 0, 0,   0,  0,   0};
    tbl[15] = '{0, 1, 1, 0, 0,   0,  0,   0};
    tbl[16] = '{0, 1, 1, 0, 0,   0,  0,   0};
    tbl[17] = '{0, 1, 1, 0, 0,   7,  1,   1};
    tbl[18] = '{1, 1, 0, 0, 0,   0,  0,   0};

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].l, tbl[i].lv);
      check_a($sformatf("tbl[%0d]", i), tbl[i].sel, tbl[i].tick, tbl[i].wrap);
    end

    // Full up-sweep after a second reset cycle: one step per 4 cycles, wrap on the 8th.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 36; i++) begin
      int es;
      int et;
      cyc(0, 1, 0, 0, 0);
      et = ((i % 4) == 3) ? 1 : 0;
      es = ((i + 1) / 4) % 8;
      check_a($sformatf("sweep[%0d]", i), es, et, (et == 1 && es == 0) ? 1 : 0);
      check($sformatf("sweep[%0d].bits", i), 32'({ifa.in2, ifa.in1, ifa.in0}), es);
    end

    // Down from 0: wrap to 7, then 6 without wrap.
    cyc(0, 0, 0, 1, 0);
    check_a("dn.load", 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, 0, 0);
      if (i == 3)      check_a("dn.wrap", 7, 1, 1);
      else if (i == 7) check_a("dn.next", 6, 1, 0);
      else             check($sformatf("dn[%0d].tick", i), 32'(ifa.tick), 0);
    end

    // Load at cnt=2: no tick, step exactly 4 cycles later; clamp on the LAST=5 instance.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 5);
    check_a("ld5", 5, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 0);
      if (i == 3) check_a("ld5.step", 6, 1, 0);
      else        check_a($sformatf("ld5.wait[%0d]", i), 5, 0, 0);
    end
    cyc(0, 1, 0, 1, 7);
    check("ld7.a.sel", 32'(ifa.sel), 7);
    check("ld7.b.sel", 32'(ifb.sel), LAST_B);

    // Pause at cnt=2 for 10 cycles, then the tick lands 2 enabled cycles later.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 0);
      check_a($sformatf("pause[%0d]", i), 7, 0, 0);
    end
    cyc(0, 1, 0, 0, 0);
    check_a("resume.1", 7, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check_a("resume.2", 0, 1, 1);

    // Reset mid-step at sel=6, cnt=3, then a full prescale period to the first step.
    cyc(0, 1, 0, 1, 6);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check_a("pre_rst", 6, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check_a("mid_rst", 0, 0, 0);
    check("mid_rst.bits", 32'({ifa.in2, ifa.in1, ifa.in0}), 0);
`ifdef SCAN_BLANK_EN
    check("mid_rst.blank", 32'(ifa.blank), 1);
`endif
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 0);
      if (i == 3) check_a("post_rst.step", 1, 1, 0);
      else        check_a($sformatf("post_rst[%0d]", i), 0, 0, 0);
    end

    // Randomized traffic against the model on both instances.
    for (int i = 0; i < 400; i++) begin
      bit r;
      bit e;
      bit d;
      bit l;
      int lv;
      r  = ($urandom_range(0, 49) == 0);
      e  = ($urandom_range(0, 3) != 0);
      d  = 1'($urandom_range(0, 1));
      l  = ($urandom_range(0, 19) == 0);
      lv = int'($urandom_range(0, 7));
      cyc(r, e, d, l, lv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
